// File: rtl/mp_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_pkg
//  Description : Shared types and helpers for the multi-precision
//                add/subtract sequencer (state encoding, word-index width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mp_add_pkg;

  // Sequencer states: waiting for an operand, stepping through the words,
  // holding the finished result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_add_state_t;

  // Narrowest legal word-index register.
  localparam int unsigned C_IDX_W_MIN = 1;

  // Width of the word index for a given word count. A single-word operand
  // still needs a 1-bit index so the register and its compares stay legal.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : C_IDX_W_MIN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/n_adder.sv
`default_nettype none
// ============================================================================
//  Module      : n_adder
//  Description : N-bit ripple adder slice with carry in and carry out.
//                Purely combinational.
//  Ports       : a, b   - N-bit addends
//                c_in   - carry into bit 0
//                s      - N-bit sum
//                c_out  - carry out of bit N-1
//  Revision    : 1.0 - initial release
// ============================================================================
module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  // One extra bit catches the carry leaving the slice.
  logic [N:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
  assign s      = w_full[N-1:0];
  assign c_out  = w_full[N];

endmodule
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq
//  Description : Multi-precision add/subtract sequencer. Computes a
//                WORDS*N-bit sum by time-sharing one N-bit adder slice over
//                WORDS cycles, least-significant word first, chaining the
//                carry through a register. Valid/ready on both sides.
//  Ports       : clk, rstn           - clock (rising edge), async active-low reset
//                in_valid/in_ready   - operand handshake (ready only in IDLE)
//                a, b                - W-bit operands
//                c_in                - carry into word 0
//                op_sub              - 1: add ~b instead of b
//                out_valid/out_ready - result handshake
//                sum, c_out, ovf     - W-bit result, final carry, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 c_in,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 c_out,
  output logic                 ovf
);

  import mp_add_pkg::*;

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);

  localparam logic [IW-1:0] C_LAST_IDX = IW'(WORDS - 1);
  localparam logic [IW-1:0] C_IDX_ONE  = IW'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  mp_add_state_t  r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b_eff;     // b already inverted for subtraction
  logic           r_carry;     // carry between words
  logic [IW-1:0]  r_idx;       // word currently being added
  logic [W-1:0]   r_sum;
  logic           r_c_out;
  logic           r_ovf;
  logic           r_out_valid;
  logic           r_in_ready;

  // --------------------------------------------------------------------------
  // Word select feeding the shared slice
  // --------------------------------------------------------------------------
  logic [N-1:0]   w_a_slice;
  logic [N-1:0]   w_b_slice;
  logic [N-1:0]   w_s;
  logic           w_c;
  logic           w_last;
  logic           w_ovf;

  // Explicit compare-and-select keeps every slice index constant, so the
  // mux is obvious to synthesis and never reads past the operand.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_slice = r_a[i*N +: N];
        w_b_slice = r_b_eff[i*N +: N];
      end
    end
  end

  n_adder #(
    .N (N)
  ) u_slice (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c)
  );

  assign w_last = (r_idx == C_LAST_IDX);

  // Signed overflow: both operands share a sign and the final sign differs.
  // The top slice output carries the final sum sign on the last word.
  assign w_ovf  = (r_a[W-1] == r_b_eff[W-1]) && (w_s[N-1] != r_a[W-1]);

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b_eff     <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Ready comes up on the first edge after reset release and
          // stays up until an operand is taken.
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b_eff    <= op_sub ? ~b : b;
            r_carry    <= c_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IW'(i)) begin
              r_sum[i*N +: N] <= w_s;
            end
          end
          r_carry <= w_c;
          if (w_last) begin
            r_c_out     <= w_c;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + C_IDX_ONE;
          end
        end

        DONE: begin
          // Result registers hold their value past the handshake; only
          // valid drops. Ready returns with the move back to IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp_add_seq
//  Description : Self-checking bench for mp_add_seq (N=8, WORDS=4). A
//                reference model predicts every result from plain wide
//                arithmetic; directed vectors pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c_in;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          ovf;

  mp_add_seq #(
    .N     (N),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int n_results = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: wide unsigned sum for {c_out,sum}, true signed range
  // test for overflow. Inputs sampled mid-cycle, opposite the active edge.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [32:0] res;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit   prev_ov = 1'b0;

  always @(negedge clk) begin
    exp_t   e;
    longint t;
    logic [W-1:0] beff;
    if (!rstn) begin
      q.delete();
      prev_ov = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  0);
      check("rst_sum",       sum,       0);
      check("rst_c_out",     c_out,     0);
      check("rst_ovf",       ovf,       0);
    end else begin
      if (in_valid && in_ready) begin
        beff  = op_sub ? ~b : b;
        e.res = {1'b0, a} + {1'b0, beff} + {32'd0, c_in};
        t     = longint'($signed(a)) + longint'($signed(beff)) + longint'(c_in);
        e.ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          check("model_sum_cout", {c_out, sum}, q[0].res);
          check("model_ovf", ovf, q[0].ov);
          if (!prev_ov) check("latency_edge", cyc, q[0].acc + WORDS);
          check("in_ready_while_done", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            n_results++;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Drivers (inputs change #1 after the rising edge)
  // --------------------------------------------------------------------------
  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("timeout_in_ready", 0, 1);
  endtask

  task automatic wait_out_valid();
    int k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic vs);
    wait_ready();
    a = va; b = vb; c_in = vc; op_sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the captured operand must not move.
    a = $urandom; b = $urandom; c_in = 1'($urandom); op_sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs, input int stall,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
    send(va, vb, vc, vs);
    wait_out_valid();
    repeat (stall) begin @(posedge clk); #1; end
    rs = sum; rc = c_out; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed and random stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    int           k;

    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Carry ripple across a word boundary, latency checked by the model.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, rs, rc, ro);
    check("ripple_sum", rs, 32'h0000_0100);
    check("ripple_cout", rc, 0);
    check("ripple_ovf", ro, 0);

    // Wrap-around and positive overflow.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, rs, rc, ro);
    check("wrap_sum", rs, 32'h0000_0000);
    check("wrap_cout", rc, 1);
    check("wrap_ovf", ro, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, rs, rc, ro);
    check("posovf_sum", rs, 32'h8000_0000);
    check("posovf_cout", rc, 0);
    check("posovf_ovf", ro, 1);

    // Subtraction.
    run_op(32'd5, 32'd10, 1'b1, 1'b1, 0, rs, rc, ro);
    check("sub_sum", rs, 32'hFFFF_FFFB);
    check("sub_cout", rc, 0);
    check("sub_ovf", ro, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, 2, rs, rc, ro);
    check("subovf_sum", rs, 32'h7FFF_FFFF);
    check("subovf_cout", rc, 1);
    check("subovf_ovf", ro, 1);

    // Backpressure: hold the result while new operands are offered.
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 32'h2345_6789);
      check("bp_cout", c_out, 0);
      check("bp_ovf", ovf, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_out_valid_drop", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    check("bp_sum_held", sum, 32'h2345_6789);

    // Reset in the middle of RUN with idx=2.
    send(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", c_out, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_op(32'd1234, -32'sd34, 1'b0, 1'b0, 0, rs, rc, ro);
    check("postrst_sum", rs, 32'd1200);
    check("postrst_cout", rc, 1);
    check("postrst_ovf", ro, 0);

    // Random operations with random consumer stalls.
    for (int i = 0; i < 200; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), rs, rc, ro);
    end

    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("result_count", n_results, 207);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
